// File: rtl/ex_muldiv_unit.sv
// Iterative unsigned multiply/divide unit for the EX stage.
// MULTU uses a 32-step shift-add and DIVU uses a 32-step restoring divider. Both
// write HI/LO on the edge that enters DONE. The unit also provides the pipeline
// stall and the MFHI/MFLO read data.
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data,
    output logic        dz
);

    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_opb;   // multiplicand for MUL, divisor for DIV
    logic [63:0] r_prod;  // {partial sum, remaining multiplier bits}
    logic [31:0] r_rem;   // partial remainder, always below the divisor
    logic [31:0] r_quo;   // dividend bits shift out as quotient bits shift in
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_dz;
    logic        r_done;
    logic        r_busy;

    logic [32:0] w_add;
    logic [63:0] w_prod_nxt;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic        w_last;
    logic        w_is_md;

    // Datapath for one multiply step and one divide step
    always_comb begin
        // The 33-bit sum keeps the carry, and it shifts into bit 63
        w_add      = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_opb} : 33'd0);
        w_prod_nxt = {w_add, r_prod[31:1]};
        // 33-bit partial remainder. A borrow out of bit 32 means the divisor does not fit
        w_shift    = {r_rem, r_quo[31]};
        w_diff     = w_shift - {1'b0, r_opb};
        w_ge       = ~w_diff[32];
        w_rem_nxt  = w_ge ? w_diff[31:0] : w_shift[31:0];
        w_quo_nxt  = {r_quo[30:0], w_ge};
        w_last     = (r_cnt == 6'd31);
    end

    // Control FSM, iteration registers and HI/LO/DZ
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_cnt   <= 6'd0;
            r_opb   <= 32'd0;
            r_prod  <= 64'd0;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_dz    <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start && !flush) begin
                        if (funct == FUNCT_MULTU) begin
                            r_opb   <= rs_val;
                            r_prod  <= {32'd0, rt_val};
                            r_cnt   <= 6'd0;
                            r_dz    <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= StMul;
                        end else if (funct == FUNCT_DIVU) begin
                            r_cnt  <= 6'd0;
                            r_busy <= 1'b1;
                            if (rt_val == 32'd0) begin
                                // Divide by zero finishes at once with a fixed result
                                r_hi    <= rs_val;
                                r_lo    <= 32'hFFFF_FFFF;
                                r_dz    <= 1'b1;
                                r_done  <= 1'b1;
                                r_state <= StDone;
                            end else begin
                                r_opb   <= rt_val;
                                r_quo   <= rs_val;
                                r_rem   <= 32'd0;
                                r_dz    <= 1'b0;
                                r_state <= StDiv;
                            end
                        end
                    end
                end
                StMul: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_prod <= w_prod_nxt;
                        r_cnt  <= r_cnt + 6'd1;
                        if (w_last) begin
                            r_hi    <= w_prod_nxt[63:32];
                            r_lo    <= w_prod_nxt[31:0];
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end
                    end
                end
                StDiv: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + 6'd1;
                        if (w_last) begin
                            r_hi    <= w_rem_nxt;
                            r_lo    <= w_quo_nxt;
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end
                    end
                end
                StDone: begin
                    // HI/LO were already written when DONE was entered, so flush changes nothing
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Stall decode and the MFHI/MFLO read mux
    always_comb begin
        w_is_md = (funct == FUNCT_MULTU) || (funct == FUNCT_DIVU) ||
                  (funct == FUNCT_MFHI)  || (funct == FUNCT_MFLO);
        stall   = (r_state != StIdle) && start && w_is_md;
        if (funct == FUNCT_MFHI) begin
            mf_data = r_hi;
        end else if (funct == FUNCT_MFLO) begin
            mf_data = r_lo;
        end else begin
            mf_data = 32'd0;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign dz   = r_dz;

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have port `clk`: input, 1 bit, single clock; all state updates on its rising edge.
REQ-002 SHALL have port `rst`: input, 1 bit, asynchronous and active-low reset.
REQ-003 SHALL have port `start`: input, 1 bit, a valid EX-stage instruction is present this cycle (driven from the ID/EX register outputs).
REQ-004 SHALL have port `funct`: input, 6 bits, EX-stage funct field. Encodings: MULTU=6'h19, DIVU=6'h1B, MFHI=6'h10, MFLO=6'h12.
REQ-005 SHALL have port `rs_val`: input, 32 bits, EX-stage RD1 operand (multiplicand / dividend).
REQ-006 SHALL have port `rt_val`: input, 32 bits, EX-stage RD2 operand (multiplier / divisor).
REQ-007 SHALL have port `flush`: input, 1 bit, abort any operation in flight.
REQ-008 SHALL have port `stall`: output, 1 bit, freeze PC, IF/ID and ID/EX this cycle.
REQ-009 SHALL have port `busy`: output, 1 bit, operation in progress.
REQ-010 SHALL have port `done`: output, 1 bit, one-cycle completion pulse.
REQ-011 SHALL have port `hi`: output, 32 bits, HI register.
REQ-012 SHALL have port `lo`: output, 32 bits, LO register.
REQ-013 SHALL have port `mf_data`: output, 32 bits, MFHI/MFLO result for the EX result mux.
REQ-014 SHALL have port `dz`: output, 1 bit, sticky divide-by-zero flag for the last DIVU.

Function
REQ-015 SHALL implement a state machine with states IDLE, MUL, DIV, DONE.
REQ-016 SHALL, in IDLE, on `start` with funct=MULTU and `flush` low: latch the operands, clear the iteration counter, clear `dz`, and enter MUL.
REQ-017 SHALL, in IDLE, on `start` with funct=DIVU, `flush` low and rt_val≠0: latch the operands, clear `dz`, and enter DIV.
REQ-018 SHALL, in IDLE, on `start` with funct=DIVU and rt_val=0: enter DONE next edge with no iterations; hi=rs_val, lo=32'hFFFFFFFF, dz=1.
REQ-019 SHALL, in MUL, perform unsigned shift-add one bit per cycle on a 64-bit product, using an explicit carry bit so that no overflow is lost, for exactly 32 cycles.
REQ-020 SHALL, in DIV, perform unsigned restoring division one quotient bit per cycle on a 33-bit partial remainder, for exactly 32 cycles.
REQ-021 SHALL enter DONE on the edge completing iteration 32, writing hi/lo on that same edge: MUL gives hi=product[63:32], lo=product[31:0]; DIV gives lo=quotient, hi=remainder.
REQ-022 SHALL assert `done` only while in DONE, for exactly one cycle, then return to IDLE.
REQ-023 SHALL set the timing as follows: start sampled in cycle 0, iterations in cycles 1-32, DONE in cycle 33, IDLE in cycle 34; divide-by-zero gives DONE in cycle 1.
REQ-024 SHALL assert `busy` whenever the state is not IDLE.
REQ-025 SHALL drive `stall` combinationally as: state≠IDLE AND start AND funct∈{MULTU, DIVU, MFHI, MFLO}.
REQ-026 SHALL drive stall=0 in IDLE.
REQ-027 SHALL not accept a start while not in IDLE; the stalled instruction is re-presented by the pipeline.
REQ-028 SHALL drive `mf_data` combinationally as hi when funct=MFHI, lo when funct=MFLO, else 0; the value is meaningful only when stall=0.
REQ-029 SHALL treat any other funct value with `start` as a no-op: no state change and stall=0.
REQ-030 SHALL give `flush` priority over `start` and over iteration: next edge returns to IDLE, hi/lo/dz unchanged, no `done` pulse.
REQ-031 SHALL, when `flush` is asserted in IDLE, take no action.
REQ-032 SHALL, when `flush` is asserted in DONE, return to IDLE; hi/lo were already written on entry to DONE and are kept.
REQ-033 SHALL keep hi/lo stable except at the DONE-entry edge.

Reset
REQ-034 SHALL, on rst=0 and immediately regardless of `clk`, force state=IDLE, counter=0, hi=0, lo=0, dz=0, done=0, busy=0.
REQ-035 SHALL, as a consequence of reset, give stall=0 and mf_data=0 combinationally.
REQ-036 SHALL, when reset is asserted mid-operation, abandon the operation with no `done` pulse.
REQ-037 SHALL resume normal operation on the first rising `clk` edge after rst returns to 1.

Verification
REQ-038 SHALL be verified by: MULTU rs=32'hFFFFFFFF, rt=32'hFFFFFFFF -> done in cycle 33, hi=32'hFFFFFFFE, lo=32'h00000001, busy in cycles 1-33.
REQ-039 SHALL be verified by: DIVU rs=100, rt=7 -> done in cycle 33, lo=14, hi=2, dz=0.
REQ-040 SHALL be verified by: DIVU rs=5, rt=0 -> done in cycle 1, hi=5, lo=32'hFFFFFFFF, dz=1; a following MULTU clears dz.
REQ-041 SHALL be verified by: MULTU 3×4, then MFHI/MFLO held on start from cycle 1 -> stall=1 in cycles 1-33, stall=0 in cycle 34, with mf_data=0 (MFHI) and 12 (MFLO).
REQ-042 SHALL be verified by: DIVU in flight, flush in cycle 10 -> IDLE in cycle 11, no done, hi/lo keep their prior values.
REQ-043 SHALL be verified by: rst driven low mid-cycle during MUL cycle 20 -> outputs 0 before the next clk edge; after release, MULTU 6×7 -> lo=42, hi=0.
